// File: rtl/adder_pkg.sv
// Shared types and helpers for the multicycle adder: FSM state encoding and a
// constant-evaluable ceil(log2) for sizing the chunk counter.
package adder_pkg;

  localparam int unsigned STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADD  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its MSB so
// the caller can derive two's-complement overflow on the top chunk.
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             msb_cin_o
);

  localparam int unsigned FULL_W = CHUNK + 1;

  logic [CHUNK:0] full;

  always_comb begin
    full = {1'b0, a_i} + {1'b0, b_i} + FULL_W'(cin_i);
  end

  assign sum_o     = full[CHUNK-1:0];
  assign cout_o    = full[CHUNK];
  // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out by XOR.
  assign msb_cin_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// Sequential WIDTH-bit adder, CHUNK bits per cycle with a registered carry.
// Optional MULTICYCLE_ADDER_OVF_EN adds overflow_out (signed overflow).
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
`ifdef MULTICYCLE_ADDER_OVF_EN
  output logic             overflow_out,
`endif
  output logic             carry_out
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CHUNK-1:0]   op_a, op_b, ch_sum;
  logic               ch_cout, ch_msb_cin;

  // Select the current chunk of each captured operand.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        op_a = a_q[i*CHUNK +: CHUNK];
        op_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .a_i      (op_a),
    .b_i      (op_b),
    .cin_i    (carry_q),
    .sum_o    (ch_sum),
    .cout_o   (ch_cout),
    .msb_cin_o(ch_msb_cin)
  );

`ifdef MULTICYCLE_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`else
  logic unused_msb_cin;
  assign unused_msb_cin = ch_msb_cin;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = carry_in;
          cnt_d   = '0;
          state_d = ST_ADD;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        for (int unsigned i = 0; i < NCHUNK; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            work_d[i*CHUNK +: CHUNK] = ch_sum;
          end
        end
        carry_d = ch_cout;
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          sum_d   = work_d;
          cout_d  = ch_cout;
`ifdef MULTICYCLE_ADDER_OVF_EN
          ovf_d   = ch_cout ^ ch_msb_cin;
`endif
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MULTICYCLE_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign sum_out   = sum_q;
  assign carry_out = cout_q;
`ifdef MULTICYCLE_ADDER_OVF_EN
  assign overflow_out = ovf_q;
`endif

endmodule
